// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types and the weight loader state encoding.
package fixed_point_pkg;

  localparam int DEF_INT_WIDTH  = 8;
  localparam int DEF_FRAC_WIDTH = 8;

  typedef logic signed [DEF_INT_WIDTH-1:-DEF_FRAC_WIDTH] fixed_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs BYTES stream bytes MSB-first into one word; pulses word_complete
// the cycle after the final byte of each word is accepted.
module byte_assembler #(
  parameter  int BYTES = 2,
  localparam int WIDTH = BYTES * 8,
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_fire,
  input  logic [7:0]       in_byte,
  output logic             last_byte,
  output logic             word_complete,
  output logic [WIDTH-1:0] word
);

  logic [CW-1:0]    byte_count;
  logic [WIDTH-1:0] assembled;

  assign last_byte = in_fire && (byte_count == CW'(BYTES - 1));

  // byte_count 0 lands in the top byte lane
  always_comb begin
    assembled = word;
    for (int b = 0; b < BYTES; b++)
      if (int'(byte_count) == BYTES - 1 - b) assembled[b*8 +: 8] = in_byte;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_count    <= '0;
      word          <= '0;
      word_complete <= 1'b0;
    end else begin
      word_complete <= last_byte;
      if (clear) begin
        byte_count <= '0;
      end else if (in_fire) begin
        word       <= assembled;
        byte_count <= last_byte ? '0 : byte_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Byte-stream to weight-RAM writer: one word per BYTES_PER_WEIGHT bytes, addresses
// 0..NUM_WEIGHTS-1. Define WEIGHT_LOADER_CHECKSUM_EN for a trailing mod-256 checksum byte.
module weight_loader
  import fixed_point_pkg::*;
#(
  parameter  int INT_WIDTH        = DEF_INT_WIDTH,
  parameter  int FRAC_WIDTH       = DEF_FRAC_WIDTH,
  parameter  int NUM_WEIGHTS      = 784,
  localparam int WIDTH            = INT_WIDTH + FRAC_WIDTH,
  localparam int BYTES_PER_WEIGHT = WIDTH / 8,
  localparam int AW               = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [7:0]                            in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  write_enable,
  output logic [AW-1:0]                         address,
  output logic signed [INT_WIDTH-1:-FRAC_WIDTH] write_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  error
);

  if ((WIDTH % 8 != 0) || (WIDTH == 0)) begin : g_bad_width
    $error("weight_loader: INT_WIDTH+FRAC_WIDTH must be a nonzero multiple of 8");
  end
  if (NUM_WEIGHTS < 1) begin : g_bad_depth
    $error("weight_loader: NUM_WEIGHTS must be at least 1");
  end

  loader_state_t    state, state_next;
  logic [AW-1:0]    word_idx;
  logic             load_fire, last_byte, word_complete, start_load, last_word;
  logic [WIDTH-1:0] word;

  assign in_ready   = (state == LOAD) || (state == CHECK);
  assign busy       = in_ready;
  assign load_fire  = in_valid && (state == LOAD);
  assign start_load = start && ((state == IDLE) || (state == DONE));
  assign last_word  = (word_idx == AW'(NUM_WEIGHTS - 1));

  byte_assembler #(.BYTES(BYTES_PER_WEIGHT)) u_asm (
    .clock         (clock),
    .reset         (reset),
    .clear         (start_load),
    .in_fire       (load_fire),
    .in_byte       (in_data),
    .last_byte     (last_byte),
    .word_complete (word_complete),
    .word          (word)
  );

  assign write_enable = word_complete;
  assign write_data   = word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:
        if (last_byte && last_word) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      CHECK: if (in_valid) state_next = DONE;
`endif
      DONE:  if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // address only moves on a write, so it holds the last written index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_idx <= '0;
      address  <= '0;
    end else if (start_load) begin
      word_idx <= '0;
    end else if (last_byte) begin
      address  <= word_idx;
      word_idx <= last_word ? word_idx : word_idx + 1'b1;
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       ck_fire;

  assign ck_fire = in_valid && (state == CHECK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum   <= '0;
      error <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= ((state == DONE) && !start) || ck_fire;
      if (start_load) begin
        sum   <= '0;
        error <= 1'b0;
      end else begin
        if (load_fire) sum <= sum + in_data;
        if (ck_fire)   error <= (in_data != sum);
      end
    end
  end
`else
  assign error = 1'b0;

  // registered from state, so done rises one cycle after entering DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) done <= 1'b0;
    else        done <= (state == DONE) && !start;
  end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader (4 weights, 8.8) against a stream-level model.
module tb_weight_loader;

  localparam int NW  = 4;
  localparam int BPW = 2;
  localparam int W   = 16;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam int CK  = 1;
`else
  localparam int CK  = 0;
`endif
  localparam int PAYLOAD = NW * BPW;
  localparam int TOTAL   = PAYLOAD + CK;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, write_enable, busy, done, error;
  logic [1:0] address;
  logic signed [7:-8] write_data;

  weight_loader #(.INT_WIDTH(8), .FRAC_WIDTH(8), .NUM_WEIGHTS(NW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .write_enable(write_enable),
    .address(address), .write_data(write_data), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- stream-level model: counts bytes accepted in the current load ----
  bit         loading = 0, fin_d1 = 0;
  int         taken = 0;
  logic [W-1:0] cur = '0;
  logic [7:0] sum = '0;
  logic       exp_ready = 0, exp_busy = 0, exp_we = 0, exp_done = 0, exp_error = 0;
  logic [1:0] exp_addr = '0;
  logic [W-1:0] exp_data = '0;
  logic [W-1:0] m_log [NW];
  logic [W-1:0] dut_log [NW];
  int         wr_cyc [NW];
  int         cyc = 0, nwr = 0, first_addr = -1;
  bit         cmp_en = 0;

  task automatic model_step();
    bit fire;
    if (!reset) begin
      loading = 0; fin_d1 = 0; taken = 0; cur = '0; sum = '0;
      exp_ready = 0; exp_busy = 0; exp_we = 0; exp_done = 0; exp_error = 0;
      exp_addr = '0; exp_data = '0;
      return;
    end
    fire   = in_valid && loading;
    exp_we = 0;
    if (fin_d1) begin exp_done = 1; fin_d1 = 0; end
    if (fire) begin
      if (taken < PAYLOAD) begin
        cur = (cur << 8) | W'(in_data);
        sum = sum + in_data;
        taken++;
        if (taken % BPW == 0) begin
          exp_we = 1; exp_addr = 2'(taken / BPW - 1); exp_data = cur;
          m_log[taken / BPW - 1] = cur;
        end
        if (taken == TOTAL) begin loading = 0; fin_d1 = 1; end
      end else begin
        taken++; loading = 0; exp_done = 1; exp_error = (in_data != sum);
      end
    end else if (start && !loading) begin
      loading = 1; taken = 0; cur = '0; sum = '0;
      exp_done = 0; exp_error = 0; fin_d1 = 0;
    end
    exp_ready = loading;
    exp_busy  = loading;
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    cyc++;
    if (cmp_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      chk("error", error, exp_error);
      chk("write_enable", write_enable, exp_we);
      chk("address", address, exp_addr);
      if (exp_we) chk("write_data", {16'h0, write_data}, {16'h0, exp_data});
      if (write_enable) begin
        if (nwr == 0) first_addr = int'(address);
        dut_log[address] = write_data;
        wr_cyc[address]  = cyc;
        nwr++;
      end
    end
  end

  // ---- stimulus ----
  logic [7:0] stream [$];

  task automatic run_load(input int gap_mode, input int start_at);
    @(negedge clock); start = 1; in_valid = 0;
    @(negedge clock); start = 0;
    foreach (stream[i]) begin
      int g;
      g = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      repeat (g) begin
        in_valid = 0; in_data = 8'($urandom); start = 0;
        @(negedge clock);
      end
      in_valid = 1; in_data = stream[i]; start = (i == start_at);
      @(negedge clock);
    end
    start = 0;
    repeat (2) begin in_valid = 1; in_data = 8'($urandom); @(negedge clock); end
    in_valid = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic set_directed(input bit with_ck, input logic [7:0] ck);
    stream = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h40, 8'h7F, 8'hFF};
    if (with_ck) stream.push_back(ck);
  endtask

  task automatic check_directed(input string tag, input int spacing);
    chk({tag, "_w0"}, {16'h0, dut_log[0]}, 32'h0180);
    chk({tag, "_w1"}, {16'h0, dut_log[1]}, 32'hFF00);
    chk({tag, "_w2"}, {16'h0, dut_log[2]}, 32'h0040);
    chk({tag, "_w3"}, {16'h0, dut_log[3]}, 32'h7FFF);
    chk({tag, "_model_w1"}, {16'h0, m_log[1]}, 32'hFF00);
    chk({tag, "_nwr"}, nwr, 4);
    chk({tag, "_spacing"}, wr_cyc[3] - wr_cyc[2], spacing);
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    logic [7:0] s, b;
    #1 reset = 0; cmp_en = 1;
    repeat (2) @(negedge clock);
    reset = 1;

    // idle: offered bytes must be refused
    nwr = 0;
    in_valid = 1; in_data = 8'hAA;
    repeat (5) @(negedge clock);
    in_valid = 0;
    chk("idle_writes", nwr, 0);

    // back-to-back directed stream
    set_directed(CK == 1, 8'h3E); nwr = 0;
    run_load(0, -1);
    check_directed("b2b", 2);
    chk("b2b_error", error, 0);

    // valid low every other cycle
    set_directed(CK == 1, 8'h3E); nwr = 0;
    run_load(1, -1);
    check_directed("gap", 4);

    // reset in the middle of a load
    @(negedge clock); start = 1;
    @(negedge clock); start = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = stream[i]; @(negedge clock);
    end
    in_valid = 0;
    @(posedge clock); #2 reset = 0;
    @(negedge clock); @(negedge clock); reset = 1;
    nwr = 0; first_addr = -1;
    set_directed(CK == 1, 8'h3E);
    run_load(0, -1);
    check_directed("rst", 2);
    chk("rst_first_addr", first_addr, 0);

    // start during LOAD is ignored; load from DONE rewrites 0..3
    set_directed(CK == 1, 8'h3E); nwr = 0;
    run_load(0, 3);
    check_directed("mid_start", 2);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    set_directed(1, 8'h3F); nwr = 0;
    run_load(0, -1);
    chk("ck_bad_error", error, 1);
    chk("ck_bad_done", done, 1);
    chk("ck_bad_nwr", nwr, 4);
`endif

    // randomized loads
    for (int it = 0; it < 30; it++) begin
      stream.delete();
      s = 8'h00;
      for (int i = 0; i < PAYLOAD; i++) begin
        b = 8'($urandom); stream.push_back(b); s = s + b;
      end
      if (CK == 1)
        stream.push_back(($urandom_range(0, 1) == 1) ? s : s ^ 8'($urandom_range(1, 255)));
      nwr = 0;
      run_load(2, int'($urandom_range(0, TOTAL + 3)));
      chk("rand_nwr", nwr, NW);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
